// File: rtl/mux_pkg.sv
// Shared definitions for the two-lane byte merge: default sizes, lane select
// encoding and the FIFO pointer-width helper.
package mux_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef enum logic {
    LANE0 = 1'b0,
    LANE1 = 1'b1
  } lane_sel_e;

  // Smallest width able to address every FIFO entry (depth is a power of 2).
  function automatic int ptr_width(input int depth);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < depth) begin
        w = i + 1;
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/fifo_lane_8bits.sv
// Per-lane synchronous FIFO with a combinational head. Pushes while full and
// pops while empty are ignored, so the owner never corrupts its state.
module fifo_lane_8bits
  import mux_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty
);

  localparam int PTR_W = ptr_width(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [CNT_W-1:0]      count_r;
  logic                  push_ok_s;
  logic                  pop_ok_s;

  assign full      = (count_r == CNT_FULL);
  assign empty     = (count_r == {CNT_W{1'b0}});
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign dout      = mem_r[rd_ptr_r];

  // Storage write; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers wrap naturally modulo the power-of-2 depth.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/mux_2x1_8bits.sv
// Re-merges two byte lanes into one stream in strict lane0/lane1 alternation,
// with per-lane FIFOs absorbing skew and a registered valid/ready output stage.
module mux_2x1_8bits
  import mux_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in0,
  input  logic                  valid_in0,
  output logic                  ready_in0,
  input  logic [DATA_WIDTH-1:0] data_in1,
  input  logic                  valid_in1,
  output logic                  ready_in1,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  input  logic                  ready_out
);

  lane_sel_e             sel_r;
  lane_sel_e             sel_nxt_s;
  logic [DATA_WIDTH-1:0] dout0_s;
  logic [DATA_WIDTH-1:0] dout1_s;
  logic                  full0_s;
  logic                  full1_s;
  logic                  empty0_s;
  logic                  empty1_s;
  logic                  pop0_s;
  logic                  pop1_s;
  logic                  out_free_s;
  logic                  load_s;
  logic [DATA_WIDTH-1:0] head_s;
  logic [DATA_WIDTH-1:0] data_out_r;
  logic                  valid_out_r;

  fifo_lane_8bits #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo0 (
    .clk  (clk),
    .reset(reset),
    .push (valid_in0),
    .pop  (pop0_s),
    .din  (data_in0),
    .dout (dout0_s),
    .full (full0_s),
    .empty(empty0_s)
  );

  fifo_lane_8bits #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo1 (
    .clk  (clk),
    .reset(reset),
    .push (valid_in1),
    .pop  (pop1_s),
    .din  (data_in1),
    .dout (dout1_s),
    .full (full1_s),
    .empty(empty1_s)
  );

  // Input readiness comes from registered FIFO state only, never a same-cycle pop.
  assign ready_in0  = !full0_s;
  assign ready_in1  = !full1_s;
  assign out_free_s = !valid_out_r || ready_out;
  assign data_out   = data_out_r;
  assign valid_out  = valid_out_r;

  // Selector register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_r <= LANE0;
    end else begin
      sel_r <= sel_nxt_s;
    end
  end

  // Load only from the selected lane; never skip ahead to the other one.
  always_comb begin
    sel_nxt_s = sel_r;
    load_s    = 1'b0;
    pop0_s    = 1'b0;
    pop1_s    = 1'b0;
    head_s    = dout0_s;
    case (sel_r)
      LANE0: begin
        head_s = dout0_s;
        if (out_free_s && !empty0_s) begin
          load_s    = 1'b1;
          pop0_s    = 1'b1;
          sel_nxt_s = LANE1;
        end else begin
          sel_nxt_s = LANE0;
        end
      end
      LANE1: begin
        head_s = dout1_s;
        if (out_free_s && !empty1_s) begin
          load_s    = 1'b1;
          pop1_s    = 1'b1;
          sel_nxt_s = LANE0;
        end else begin
          sel_nxt_s = LANE1;
        end
      end
      default: begin
        sel_nxt_s = LANE0;
      end
    endcase
  end

  // Output stage; data_out keeps its last byte when idle and is cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out_r  <= {DATA_WIDTH{1'b0}};
      valid_out_r <= 1'b0;
    end else if (load_s) begin
      data_out_r  <= head_s;
      valid_out_r <= 1'b1;
    end else if (out_free_s) begin
      valid_out_r <= 1'b0;
    end else begin
      valid_out_r <= valid_out_r;
    end
  end

endmodule

// File: tb/tb_mux_2x1_8bits.sv
// Directed and randomised checks of the two-lane merge: reset, ordering,
// skew without skipping, full FIFOs, backpressure hold and pointer wrap.
module tb_mux_2x1_8bits;

  logic       clk;
  logic       reset;
  logic [7:0] data_in0;
  logic       valid_in0;
  logic       ready_in0;
  logic [7:0] data_in1;
  logic       valid_in1;
  logic       ready_in1;
  logic [7:0] data_out;
  logic       valid_out;
  logic       ready_out;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic       sel_m;
  int         pass_cnt;
  int         fail_cnt;
  int         total_cnt;

  mux_2x1_8bits #(
    .DATA_WIDTH(8),
    .FIFO_DEPTH(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .data_in0 (data_in0),
    .valid_in0(valid_in0),
    .ready_in0(ready_in0),
    .data_in1 (data_in1),
    .valid_in1(valid_in1),
    .ready_in1(ready_in1),
    .data_out (data_out),
    .valid_out(valid_out),
    .ready_out(ready_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: record accepted input bytes, score any output transfer, return at posedge+1.
  task automatic cycle();
    logic [7:0] e;
    @(negedge clk);
    if (valid_in0 && ready_in0) q0.push_back(data_in0);
    if (valid_in1 && ready_in1) q1.push_back(data_in1);
    if (valid_out && ready_out) begin
      e = 8'hxx;
      if (sel_m == 1'b0) begin
        if (q0.size() > 0) e = q0.pop_front();
      end else begin
        if (q1.size() > 0) e = q1.pop_front();
      end
      chk("sb_data", data_out, e);
      sel_m = ~sel_m;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s0;
    int s1;
    logic acc0;
    logic acc1;
    clk = 1'b0; reset = 1'b0; ready_out = 1'b0;
    data_in0 = 8'h00; valid_in0 = 1'b0; data_in1 = 8'h00; valid_in1 = 1'b0;
    sel_m = 1'b0; pass_cnt = 0; fail_cnt = 0; total_cnt = 0;

    // Power-up reset, checked before any clock edge
    #1 reset = 1'b1;
    #2;
    chk("rst_valid", {7'd0, valid_out}, 8'h00);
    chk("rst_data", data_out, 8'h00);
    chk("rst_rdy0", {7'd0, ready_in0}, 8'h01);
    chk("rst_rdy1", {7'd0, ready_in1}, 8'h01);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;

    // Reset mid-stream with three bytes buffered (one in output stage)
    valid_in0 = 1'b1; data_in0 = 8'hA5; valid_in1 = 1'b1; data_in1 = 8'hB5;
    cycle();
    data_in0 = 8'hC5; valid_in1 = 1'b0;
    cycle();
    valid_in0 = 1'b0;
    cycle();
    chk("mid_pre_data", data_out, 8'hA5);
    #2 reset = 1'b1;
    #1;
    chk("mid_valid", {7'd0, valid_out}, 8'h00);
    chk("mid_data", data_out, 8'h00);
    chk("mid_rdy0", {7'd0, ready_in0}, 8'h01);
    chk("mid_rdy1", {7'd0, ready_in1}, 8'h01);
    q0.delete(); q1.delete(); sel_m = 1'b0;
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;

    // First output after reset must come from lane0 even if lane1 arrives first
    ready_out = 1'b1;
    valid_in1 = 1'b1; data_in1 = 8'hE1;
    cycle();
    valid_in1 = 1'b0; valid_in0 = 1'b1; data_in0 = 8'hE0;
    cycle();
    valid_in0 = 1'b0;
    cycle();
    chk("post_rst_first", data_out, 8'hE0);
    chk("post_rst_valid", {7'd0, valid_out}, 8'h01);
    cycle();
    cycle();

    // Ordered merge, no bubbles once both lanes hold data
    valid_in0 = 1'b1; data_in0 = 8'hA0; valid_in1 = 1'b1; data_in1 = 8'hB0;
    cycle();
    data_in0 = 8'hA1; data_in1 = 8'hB1;
    cycle();
    valid_in0 = 1'b0; valid_in1 = 1'b0;
    chk("merge_first", data_out, 8'hA0);
    for (int i = 0; i < 4; i++) begin
      chk("merge_nobubble", {7'd0, valid_out}, 8'h01);
      cycle();
    end
    chk("merge_drained", {7'd0, valid_out}, 8'h00);

    // Skew: lane1 early, lane0 late; output waits on lane0
    valid_in1 = 1'b1; data_in1 = 8'h11;
    cycle();
    data_in1 = 8'h12;
    cycle();
    valid_in1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("skew_wait", {7'd0, valid_out}, 8'h00);
      cycle();
    end
    valid_in0 = 1'b1; data_in0 = 8'h01;
    cycle();
    valid_in0 = 1'b0;
    cycle();
    chk("skew_first", data_out, 8'h01);
    cycle();
    chk("skew_second", data_out, 8'h11);
    cycle();
    chk("skew_12_waits", {7'd0, valid_out}, 8'h00);
    cycle();
    chk("skew_12_still", {7'd0, valid_out}, 8'h00);
    valid_in0 = 1'b1; data_in0 = 8'h02;
    cycle();
    valid_in0 = 1'b0;
    repeat (4) cycle();

    // Full FIFOs with the output stage stalled
    ready_out = 1'b0;
    for (int i = 0; i < 5; i++) begin
      valid_in0 = 1'b1; data_in0 = 8'h30 + 8'(i);
      valid_in1 = (i < 4); data_in1 = 8'h40 + 8'(i);
      cycle();
    end
    valid_in1 = 1'b0; valid_in0 = 1'b1; data_in0 = 8'hFF;
    chk("full_rdy0", {7'd0, ready_in0}, 8'h00);
    chk("full_rdy1", {7'd0, ready_in1}, 8'h00);
    chk("full_out_data", data_out, 8'h30);
    cycle();
    cycle();
    chk("full_rdy0_hold", {7'd0, ready_in0}, 8'h00);
    valid_in0 = 1'b0;
    ready_out = 1'b1;
    repeat (11) cycle();
    chk("full_drained", {7'd0, valid_out}, 8'h00);

    // Backpressure hold, then next byte from the opposite lane
    ready_out = 1'b0;
    valid_in1 = 1'b1; data_in1 = 8'h5A; valid_in0 = 1'b1; data_in0 = 8'h66;
    cycle();
    valid_in0 = 1'b0; valid_in1 = 1'b0;
    cycle();
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold_data", data_out, 8'h5A);
      chk("bp_hold_valid", {7'd0, valid_out}, 8'h01);
      cycle();
    end
    ready_out = 1'b1;
    cycle();
    chk("bp_next_lane", data_out, 8'h66);
    cycle();

    // Wrap-around: 20 bytes per lane with random valid and ready
    s0 = 0; s1 = 0;
    for (int c = 0; c < 2000 && (s0 < 20 || s1 < 20); c++) begin
      valid_in0 = (s0 < 20) && ($urandom_range(0, 3) != 0);
      data_in0  = 8'h80 + 8'(s0);
      valid_in1 = (s1 < 20) && ($urandom_range(0, 3) != 0);
      data_in1  = 8'hC0 + 8'(s1);
      ready_out = ($urandom_range(0, 2) != 0);
      acc0 = valid_in0 && ready_in0;
      acc1 = valid_in1 && ready_in1;
      cycle();
      if (acc0) s0++;
      if (acc1) s1++;
    end
    valid_in0 = 1'b0; valid_in1 = 1'b0; ready_out = 1'b1;
    for (int c = 0; c < 200 && (q0.size() > 0 || q1.size() > 0 || valid_out); c++) begin
      cycle();
    end
    chk("wrap_sent0", 8'(s0), 8'd20);
    chk("wrap_sent1", 8'(s1), 8'd20);
    chk("wrap_left0", 8'(q0.size()), 8'd0);
    chk("wrap_left1", 8'(q1.size()), 8'd0);
    chk("wrap_idle", {7'd0, valid_out}, 8'h00);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mux_2x1_8bits.md
Name: mux_2x1_8bits

Overview:
Transmit-side counterpart of the 1x2 8-bit lane demux. It re-merges two 8-bit lanes into one byte stream in strict alternation: lane0 byte, then lane1 byte, repeating. This restores the original order that the demux split across the lanes. Each lane has a small input FIFO so lanes may arrive skewed, and a registered output stage provides valid/ready backpressure. The block sits between the per-lane datapaths and the serial byte consumer.

Parameters:
DATA_WIDTH, 8, byte width of every lane and of the output
FIFO_DEPTH, 4, entries per lane FIFO; must be a power of 2 and at least 2

Ports:
clk  input  1  single block clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high reset
data_in0  input  DATA_WIDTH  lane0 byte
valid_in0  input  1  lane0 byte present
ready_in0  output  1  lane0 FIFO can accept a byte
data_in1  input  DATA_WIDTH  lane1 byte
valid_in1  input  1  lane1 byte present
ready_in1  output  1  lane1 FIFO can accept a byte
data_out  output  DATA_WIDTH  merged byte
valid_out  output  1  data_out holds a valid byte
ready_out  input  1  consumer accepts data_out this cycle

Behaviour:
- Interface: one clock (clk). Reset (reset) is asynchronous and active-high.
- While reset is high: both FIFOs are emptied (pointers and count = 0), sel = LANE0, valid_out = 0, data_out = 0, ready_in0 = ready_in1 = 1.
- Reset asserted mid-operation discards all buffered and output bytes immediately, with no clock required.
- Input push: on a rising edge where valid_inX && ready_inX, data_inX is written to FIFO X.
- ready_inX = !fullX. It is registered-state based only and never depends on a same-cycle pop.
- FIFO X push and pop in the same cycle while not full: both happen and the count is unchanged.
- valid_inX while full: the byte is not accepted and the source must hold it. There is no overflow and no state change.
- Selector FSM, states LANE0 and LANE1:
  - Stage load condition: out_free = !valid_out || ready_out.
  - Load occurs when out_free && FIFO(sel) is non-empty.
  - On load: data_out <= head(sel), valid_out <= 1, pop FIFO(sel), sel toggles.
  - When out_free and FIFO(sel) is empty: no load, valid_out <= 0, sel holds.
  - The block never skips to the other lane, even if that lane has data. Strict order is mandatory.
- While valid_out && !ready_out: data_out and valid_out hold stable and sel holds.
- Latency: a byte pushed at edge N (into an empty FIFO, with its lane selected and out_free) appears on data_out with valid_out = 1 after edge N+1.
  - Sustained throughput is one byte per clock when both lanes keep pace with half the output rate.
- Back-to-back: valid_out && ready_out with the next lane non-empty reloads at the same edge, leaving no bubble.
- Wrap-around: FIFO pointers are log2(FIFO_DEPTH) bits and wrap modulo depth. The count is log2(FIFO_DEPTH)+1 bits.
  - fullX = (count == FIFO_DEPTH); emptyX = (count == 0).
- data_out retains its last value when valid_out = 0. It is zeroed only by reset.

Decomposition:
- Package mux_pkg:
  - DATA_WIDTH default
  - lane select encoding: LANE0 = 1'b0, LANE1 = 1'b1
  - a function computing the pointer width from FIFO_DEPTH
- Sub-module fifo_lane_8bits (synchronous FIFO):
  - ports: clk, reset, push, pop, din, dout (combinational head), full, empty
  - instantiated twice
- Top holds the selector FSM and the output register only.

Test Plan:
- Reset: assert reset mid-stream with 3 bytes buffered -> valid_out = 0, data_out = 8'h00, ready_in0/1 = 1 immediately without a clock; after release, the first output comes from lane0.
- Ordered merge: lane0 pushes 8'hA0, 8'hA1 and lane1 pushes 8'hB0, 8'hB1 on consecutive edges, ready_out = 1 -> data_out sequence A0, B0, A1, B1 with no bubbles once both lanes have data.
- Skew/no-skip: lane1 pushes 8'h11, 8'h12 first and lane0 idle for 5 cycles, then lane0 pushes 8'h01 -> valid_out stays 0 until 8'h01 is output; then 8'h11 follows; 8'h12 waits for the next lane0 byte.
- Full FIFO: ready_out = 0 with 4 bytes pushed per lane, plus 1 more held in the output stage -> ready_in0 = ready_in1 = 0; a 5th valid_in0 byte 8'hFF is not accepted and FIFO contents are unchanged.
- Backpressure hold: valid_out = 1 with data_out = 8'h5A and ready_out = 0 for 3 cycles -> data_out and valid_out stable; ready_out = 1 -> next byte from the opposite lane at the following edge.
- Wrap-around: stream 20 bytes per lane alternately with random ready_out -> output equals the interleaved input order exactly and no byte is lost or duplicated.
